regfile_seq: RTL

Parametrised sequential register file with integrated instruction decoder for the microcode processor. It holds NREG registers of DATA_W bits and executes register-transfer micro-ops: load from bus, register move, drive to bus, increment, multi-cycle swap and sequential clear. It accepts one instruction at a time through a valid/ready handshake. It sits between the microcode sequencer, which issues instructions, and the shared data bus/ALU.

---
 rtl/regfile_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/regfile_seq.sv
// Sequential register file with built-in micro-op decoder: LDI/MOV/OUT/INC/SWAP/CLR.
// Optional REGFILE_SEQ_ZERO_REG_EN hardwires reg[0] to zero.
module regfile_seq #(
    parameter int DATA_W = 4,
    parameter int NREG   = 4,
    parameter int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3+2*AW:0]   instr,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              done,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

`ifdef REGFILE_SEQ_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_MOV  = 4'd2;
    localparam logic [3:0] OP_OUT  = 4'd3;
    localparam logic [3:0] OP_INC  = 4'd4;
    localparam logic [3:0] OP_SWAP = 4'd5;
    localparam logic [3:0] OP_CLR  = 4'd6;

    typedef enum logic [1:0] {
        IDLE,
        SWAP2,
        CLR
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   regs_q [NREG];
    logic [DATA_W-1:0]   regs_d [NREG];
    logic [DATA_W-1:0]   regs_rd [NREG];
    logic [DATA_W-1:0]   tmp_q, tmp_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]       swap_rs_q, swap_rs_d;
    logic [DATA_W-1:0]   bus_out_q, bus_out_d;
    logic                bus_oe_q, bus_oe_d;
    logic                done_q, done_d;

    logic [3:0]          opcode;
    logic [AW-1:0]       rd;
    logic [AW-1:0]       rs;
    logic                accept;

    assign opcode = instr[3+2*AW -: 4];
    assign rd     = instr[2*AW-1 -: AW];
    assign rs     = instr[AW-1:0];

    assign instr_ready = (state_q == IDLE) && rst_n;
    assign accept      = instr_valid && instr_ready;

    // Read view of the array: reg[0] reads as zero when it is hardwired.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_rd[i] = (ZERO_REG && i == 0) ? '0 : regs_q[i];
        end
    end

    function automatic logic wr_allowed(input logic [AW-1:0] a);
        return !(ZERO_REG && a == '0);
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        regs_d    = regs_q;
        tmp_d     = tmp_q;
        cnt_d     = cnt_q;
        swap_rs_d = swap_rs_q;
        bus_out_d = bus_out_q;
        bus_oe_d  = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    done_d = 1'b1;
                    case (opcode)
                        OP_NOP: ;
                        OP_LDI: if (wr_allowed(rd)) regs_d[rd] = bus_in;
                        OP_MOV: if (wr_allowed(rd)) regs_d[rd] = regs_rd[rs];
                        OP_OUT: begin
                            bus_out_d = regs_rd[rs];
                            bus_oe_d  = 1'b1;
                        end
                        OP_INC: if (wr_allowed(rd)) regs_d[rd] = regs_rd[rd] + DATA_W'(1);
                        OP_SWAP: begin
                            tmp_d     = regs_rd[rd];
                            swap_rs_d = rs;
                            if (wr_allowed(rd)) regs_d[rd] = regs_rd[rs];
                            state_d   = SWAP2;
                            done_d    = 1'b0;
                        end
                        OP_CLR: begin
                            regs_d[0] = '0;
                            cnt_d     = AW'(1);
                            state_d   = CLR;
                            done_d    = 1'b0;
                        end
                        default: ;  // reserved opcodes complete as NOP
                    endcase
                end
            end
            SWAP2: begin
                if (wr_allowed(swap_rs_q)) regs_d[swap_rs_q] = tmp_q;
                state_d = IDLE;
                done_d  = 1'b1;
            end
            CLR: begin
                regs_d[cnt_q] = '0;
                cnt_d         = cnt_q + AW'(1);
                if (cnt_q == AW'(NREG-1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the register array is reset explicitly; a cleared file is architecturally visible.
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            state_q   <= IDLE;
            tmp_q     <= '0;
            cnt_q     <= '0;
            swap_rs_q <= '0;
            bus_out_q <= '0;
            bus_oe_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            regs_q    <= regs_d;
            state_q   <= state_d;
            tmp_q     <= tmp_d;
            cnt_q     <= cnt_d;
            swap_rs_q <= swap_rs_d;
            bus_out_q <= bus_out_d;
            bus_oe_q  <= bus_oe_d;
            done_q    <= done_d;
        end
    end

    assign bus_out  = bus_out_q;
    assign bus_oe   = bus_oe_q;
    assign done     = done_q;
    assign dbg_data = regs_rd[dbg_addr];

endmodule
